// File: rtl/fma_sum_normalizer_pkg.sv
// Shared widths and stage payload for the FMA sum normalizer and its neighbours.
package fma_sum_normalizer_pkg;

   localparam int SIG_WIDTH = 23;
   localparam int EXP_WIDTH = 10;
   localparam int W         = 3 * (SIG_WIDTH + 1) + 7;
   localparam int LZC_WIDTH = $clog2(W + 2);

   typedef struct packed {
      logic [W:0]           mag;
      logic [EXP_WIDTH-1:0] exp;
      logic [LZC_WIDTH-1:0] lzc;
      logic                 sign_flip;
      logic                 zero;
   } stage_t;

endpackage

// File: rtl/fma_sum_normalizer_if.sv
// Adder-side input and rounder-side output handshakes of the sum normalizer.
interface fma_sum_normalizer_if;
   import fma_sum_normalizer_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [W-1:0]         in_sum;
   logic                 in_cout;
   logic                 in_eff_sub;
   logic [EXP_WIDTH-1:0] in_exp;

   logic                 out_valid;
   logic                 out_ready;
   logic [SIG_WIDTH:0]   out_mant;
   logic                 out_guard;
   logic                 out_sticky;
   logic [EXP_WIDTH-1:0] out_exp;
   logic                 out_sign_flip;
   logic                 out_zero;

   modport master (
      output in_valid, in_sum, in_cout, in_eff_sub, in_exp, out_ready,
      input  in_ready, out_valid, out_mant, out_guard, out_sticky,
             out_exp, out_sign_flip, out_zero
   );

   modport slave (
      input  in_valid, in_sum, in_cout, in_eff_sub, in_exp, out_ready,
      output in_ready, out_valid, out_mant, out_guard, out_sticky,
             out_exp, out_sign_flip, out_zero
   );

endinterface

// File: rtl/fma_sum_normalizer_lzc_tree.sv
// Combinational two-level leading-zero counter: per-byte counts, then first non-zero byte.
module fma_sum_normalizer_lzc_tree #(
   parameter int N  = 80,
   parameter int CW = 7
) (
   input  logic [N-1:0]  i_vec,
   output logic [CW-1:0] o_lzc
);

   localparam int G  = 8;
   localparam int NG = (N + G - 1) / G;
   localparam int PW = NG * G;

   logic [PW-1:0] w_pad;
   logic [G-1:0]  w_grp;
   logic [NG-1:0] w_nz;
   logic [CW-1:0] w_cnt [NG];

   // Low padding is all ones so an all-zero input still counts to exactly N.
   always_comb begin
      w_pad = '1;
      w_pad[PW-1 -: N] = i_vec;
      w_grp = '0;
      w_nz  = '0;
      for (int g = 0; g < NG; g++) begin
         w_grp    = w_pad[PW-1-g*G -: G];
         w_nz[g]  = |w_grp;
         w_cnt[g] = '0;
         for (int b = 0; b < G; b++) begin
            if (w_grp[b]) w_cnt[g] = CW'(G - 1 - b);
         end
      end
   end

   always_comb begin
      o_lzc = CW'(N);
      for (int g = NG - 1; g >= 0; g--) begin
         if (w_nz[g]) o_lzc = CW'(g * G) + w_cnt[g];
      end
   end

endmodule

// File: rtl/fma_sum_normalizer.sv
// Three-stage magnitude / leading-zero count / left-normalize pipeline after the FMA adder.
// FMA_NORM_STICKY_EN: when defined, out_sticky is the OR of all bits below guard; otherwise 0.
module fma_sum_normalizer
   import fma_sum_normalizer_pkg::*;
(
   input logic                 clk,
   input logic                 rst_n,
   fma_sum_normalizer_if.slave bus
);

   logic   r_v1, r_v2, r_v3;
   stage_t r_s1, r_s2;
   stage_t w_s1_d, w_s2_d;

   logic [SIG_WIDTH:0]   r_mant;
   logic                 r_guard, r_sticky, r_sign_flip, r_zero;
   logic [EXP_WIDTH-1:0] r_exp;

   logic w_ld1, w_ld2, w_ld3;

   // A stage loads when empty or when the stage after it is loading this cycle.
   assign w_ld3        = !r_v3 || bus.out_ready;
   assign w_ld2        = !r_v2 || w_ld3;
   assign w_ld1        = !r_v1 || w_ld2;
   assign bus.in_ready = w_ld1;

   always_comb begin
      w_s1_d           = '0;
      w_s1_d.exp       = bus.in_exp;
      w_s1_d.sign_flip = bus.in_eff_sub && !bus.in_cout;
      if (!bus.in_eff_sub)
         w_s1_d.mag = {bus.in_cout, bus.in_sum};
      else if (bus.in_cout)
         w_s1_d.mag = {1'b0, bus.in_sum};
      else
         w_s1_d.mag = {1'b0, ~bus.in_sum + W'(1)};
   end

   logic [LZC_WIDTH-1:0] w_lzc;

   fma_sum_normalizer_lzc_tree #(
      .N  (W + 1),
      .CW (LZC_WIDTH)
   ) u_lzc (
      .i_vec (r_s1.mag),
      .o_lzc (w_lzc)
   );

   always_comb begin
      w_s2_d      = r_s1;
      w_s2_d.lzc  = w_lzc;
      w_s2_d.zero = (w_lzc == LZC_WIDTH'(W + 1));
   end

   logic [SIG_WIDTH:0]   w_mant;
   logic                 w_guard, w_sticky;
   logic [EXP_WIDTH-1:0] w_exp;

`ifdef FMA_NORM_STICKY_EN
   logic [W:0] w_sh;
   assign w_sh     = r_s2.mag << r_s2.lzc;
   assign w_mant   = w_sh[W -: SIG_WIDTH+1];
   assign w_guard  = w_sh[W-SIG_WIDTH-1];
   assign w_sticky = |w_sh[W-SIG_WIDTH-2:0];
`else
   typedef logic [SIG_WIDTH+1:0] top_t;
   top_t w_sh_top;
   assign w_sh_top = top_t'((r_s2.mag << r_s2.lzc) >> (W - SIG_WIDTH - 1));
   assign w_mant   = w_sh_top[SIG_WIDTH+1:1];
   assign w_guard  = w_sh_top[0];
   assign w_sticky = 1'b0;
`endif

   assign w_exp = r_s2.zero ? '0 : r_s2.exp - EXP_WIDTH'(r_s2.lzc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_s1 <= '0;
      end else if (w_ld1) begin
         r_v1 <= bus.in_valid;
         if (bus.in_valid) r_s1 <= w_s1_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2 <= 1'b0;
         r_s2 <= '0;
      end else if (w_ld2) begin
         r_v2 <= r_v1;
         if (r_v1) r_s2 <= w_s2_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v3        <= 1'b0;
         r_mant      <= '0;
         r_guard     <= 1'b0;
         r_sticky    <= 1'b0;
         r_exp       <= '0;
         r_sign_flip <= 1'b0;
         r_zero      <= 1'b0;
      end else if (w_ld3) begin
         r_v3 <= r_v2;
         if (r_v2) begin
            r_mant      <= w_mant;
            r_guard     <= w_guard;
            r_sticky    <= w_sticky;
            r_exp       <= w_exp;
            r_sign_flip <= r_s2.sign_flip;
            r_zero      <= r_s2.zero;
         end
      end
   end

   assign bus.out_valid     = r_v3;
   assign bus.out_mant      = r_mant;
   assign bus.out_guard     = r_guard;
   assign bus.out_sticky    = r_sticky;
   assign bus.out_exp       = r_exp;
   assign bus.out_sign_flip = r_sign_flip;
   assign bus.out_zero      = r_zero;

endmodule
